// File: rtl/score_rank_display.sv
// score_rank_display: builds a sorted top-N leaderboard from a streamed scoreboard dump
// and cycles its ranks onto the display outputs. Optional BCD readout: SCORE_RANK_DISPLAY_BCD_EN.
module score_rank_display #(
    parameter int unsigned TOP_N = 4,
    parameter int unsigned DWELL = 50_000_000,
    parameter int unsigned RW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   sb_entry,
    input  logic          sb_parity,
    output logic [RW-1:0] disp_rank,
    output logic [15:0]   disp_userid,
    output logic [15:0]   disp_score,
    output logic          disp_valid,
    output logic          busy,
    output logic          done
`ifdef SCORE_RANK_DISPLAY_BCD_EN
    ,
    output logic [19:0]   disp_score_bcd
`endif
);

    localparam int unsigned    DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [31:0]    END_MARK   = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [15:0] userid;
        logic [15:0] score;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_INSERT, S_SHOW} state_t;

    state_t                 state_q, state_d;
    logic                   par_q;
    entry_t                 hold_q, hold_d;
    entry_t                 pend_q, pend_d;
    logic                   pend_v_q, pend_v_d;
    entry_t [TOP_N-1:0]     slot_q, slot_d, ins_slot;
    logic   [TOP_N-1:0]     gt;
    logic   [DCW-1:0]       dwell_q, dwell_d;
    logic   [RW-1:0]        disp_rank_q, disp_rank_d;
    logic   [15:0]          disp_userid_q, disp_userid_d;
    logic   [15:0]          disp_score_q, disp_score_d;
    logic                   disp_valid_q, disp_valid_d, disp_valid_pre;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   new_ev, is_end, rank_wrap;
    entry_t                 in_ent, sel_slot;
    logic   [15:0]          nxt_score;

    assign new_ev = (sb_parity != par_q);
    assign is_end = (sb_entry == END_MARK);
    assign in_ent = entry_t'(sb_entry);

    // Sorted insert: slots are descending, so gt is a suffix mask; a zero score never wins.
    always_comb begin
        for (int i = 0; i < int'(TOP_N); i++) begin
            gt[i] = (hold_q.score > slot_q[i].score);
        end
        ins_slot[0] = gt[0] ? hold_q : slot_q[0];
        for (int i = 1; i < int'(TOP_N); i++) begin
            ins_slot[i] = !gt[i] ? slot_q[i] : (gt[i-1] ? slot_q[i-1] : hold_q);
        end
    end

    // Current slot on display and the score of the slot after it (0 past the end).
    always_comb begin
        sel_slot  = slot_q[0];
        nxt_score = 16'd0;
        for (int i = 0; i < int'(TOP_N); i++) begin
            if (disp_rank_q == RW'(i)) sel_slot = slot_q[i];
        end
        for (int i = 1; i < int'(TOP_N); i++) begin
            if (disp_rank_q == RW'(i - 1)) nxt_score = slot_q[i].score;
        end
        rank_wrap = (nxt_score == 16'd0);
    end

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        pend_d         = pend_q;
        pend_v_d       = pend_v_q;
        slot_d         = slot_q;
        dwell_d        = dwell_q;
        disp_rank_d    = disp_rank_q;
        disp_userid_d  = 16'd0;
        disp_score_d   = 16'd0;
        disp_valid_pre = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (new_ev && !is_end) begin
                    slot_d  = '0;
                    hold_d  = in_ent;
                    state_d = S_INSERT;
                end
            end
            S_COLLECT: begin
                if (pend_v_q) begin
                    hold_d   = pend_q;
                    pend_v_d = 1'b0;
                    state_d  = S_INSERT;
                    if (new_ev && !is_end) begin
                        pend_d   = in_ent;
                        pend_v_d = 1'b1;
                    end
                end else if (new_ev && !is_end) begin
                    hold_d  = in_ent;
                    state_d = S_INSERT;
                end else if (is_end) begin
                    dwell_d     = '0;
                    disp_rank_d = '0;
                    state_d     = S_SHOW;
                end
            end
            S_INSERT: begin
                slot_d  = ins_slot;
                state_d = S_COLLECT;
                // Second register stage so a toggle during the insert cycle is kept.
                if (new_ev && !is_end) begin
                    pend_d   = in_ent;
                    pend_v_d = 1'b1;
                end
            end
            S_SHOW: begin
                if (new_ev && !is_end) begin
                    slot_d      = '0;
                    hold_d      = in_ent;
                    pend_v_d    = 1'b0;
                    disp_rank_d = '0;
                    state_d     = S_INSERT;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d     = '0;
                    disp_rank_d = rank_wrap ? '0 : disp_rank_q + RW'(1);
                end else begin
                    dwell_d = dwell_q + DCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_SHOW) begin
            disp_userid_d  = sel_slot.userid;
            disp_score_d   = sel_slot.score;
            disp_valid_pre = (slot_q[0].score != 16'd0);
        end
        busy_d = (state_d == S_COLLECT) || (state_d == S_INSERT);
        done_d = (state_d == S_SHOW);
    end

`ifdef SCORE_RANK_DISPLAY_BCD_EN
    logic [4:0]  conv_cnt_q, conv_cnt_d;
    logic        conv_act_q, conv_act_d;
    logic [15:0] conv_bin_q, conv_bin_d;
    logic [19:0] conv_bcd_q, conv_bcd_d;
    logic [19:0] bcd_out_q, bcd_out_d;
    logic [19:0] bcd_adj;
    logic [15:0] load_score;
    logic        rank_load;

    // Sequential double-dabble, restarted whenever a new rank is put on display.
    always_comb begin
        conv_cnt_d = conv_cnt_q;
        conv_act_d = conv_act_q;
        conv_bin_d = conv_bin_q;
        conv_bcd_d = conv_bcd_q;
        bcd_out_d  = bcd_out_q;
        load_score = slot_q[0].score;
        for (int i = 0; i < int'(TOP_N); i++) begin
            if (disp_rank_d == RW'(i)) load_score = slot_q[i].score;
        end
        for (int k = 0; k < 5; k++) begin
            bcd_adj[4*k +: 4] = (conv_bcd_q[4*k +: 4] >= 4'd5) ?
                                4'(conv_bcd_q[4*k +: 4] + 4'd3) : conv_bcd_q[4*k +: 4];
        end
        rank_load = (state_d == S_SHOW) &&
                    ((state_q != S_SHOW) || (disp_rank_d != disp_rank_q));

        if (rank_load) begin
            conv_act_d = 1'b1;
            conv_cnt_d = 5'd16;
            conv_bin_d = load_score;
            conv_bcd_d = 20'd0;
        end else if (conv_act_q) begin
            if (conv_cnt_q != 5'd0) begin
                {conv_bcd_d, conv_bin_d} = {bcd_adj, conv_bin_q} << 1;
                conv_cnt_d = conv_cnt_q - 5'd1;
            end else begin
                bcd_out_d  = conv_bcd_q;
                conv_act_d = 1'b0;
            end
        end
        if (state_d != S_SHOW) conv_act_d = 1'b0;
    end

    assign disp_valid_d   = disp_valid_pre && !conv_act_d;
    assign disp_score_bcd = bcd_out_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            conv_cnt_q <= 5'd0;
            conv_act_q <= 1'b0;
            conv_bin_q <= 16'd0;
            conv_bcd_q <= 20'd0;
            bcd_out_q  <= 20'd0;
        end else begin
            conv_cnt_q <= conv_cnt_d;
            conv_act_q <= conv_act_d;
            conv_bin_q <= conv_bin_d;
            conv_bcd_q <= conv_bcd_d;
            bcd_out_q  <= bcd_out_d;
        end
    end
`else
    assign disp_valid_d = disp_valid_pre;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            par_q         <= sb_parity;
            hold_q        <= '0;
            pend_q        <= '0;
            pend_v_q      <= 1'b0;
            slot_q        <= '0;
            dwell_q       <= '0;
            disp_rank_q   <= '0;
            disp_userid_q <= 16'd0;
            disp_score_q  <= 16'd0;
            disp_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            par_q         <= sb_parity;
            hold_q        <= hold_d;
            pend_q        <= pend_d;
            pend_v_q      <= pend_v_d;
            slot_q        <= slot_d;
            dwell_q       <= dwell_d;
            disp_rank_q   <= disp_rank_d;
            disp_userid_q <= disp_userid_d;
            disp_score_q  <= disp_score_d;
            disp_valid_q  <= disp_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign disp_rank   = disp_rank_q;
    assign disp_userid = disp_userid_q;
    assign disp_score  = disp_score_q;
    assign disp_valid  = disp_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_score_rank_display.sv
// Randomized bench for score_rank_display against a top-N selection model.
module tb_score_rank_display;

    localparam int unsigned TOP_N = 4;
    localparam int unsigned DWELL = 4;
    localparam int unsigned RW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   sb_entry = 32'd0;
    logic          sb_parity = 1'b1;
    logic [RW-1:0] disp_rank;
    logic [15:0]   disp_userid, disp_score;
    logic          disp_valid, busy, done;
`ifdef SCORE_RANK_DISPLAY_BCD_EN
    logic [19:0]   disp_score_bcd;
`endif

    score_rank_display #(.TOP_N(TOP_N), .DWELL(DWELL), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sb_entry    (sb_entry),
        .sb_parity   (sb_parity),
        .disp_rank   (disp_rank),
        .disp_userid (disp_userid),
        .disp_score  (disp_score),
        .disp_valid  (disp_valid),
        .busy        (busy),
        .done        (done)
`ifdef SCORE_RANK_DISPLAY_BCD_EN
        ,
        .disp_score_bcd (disp_score_bcd)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [15:0] q_uid[$];
    logic [15:0] q_sc[$];
    logic [15:0] exp_uid[TOP_N];
    logic [15:0] exp_sc[TOP_N];
    int          exp_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Top-N of all nonzero arrivals; strict > keeps the earlier arrival ahead on ties.
    task automatic build_model();
        bit taken[$];
        int best;
        taken = {};
        foreach (q_sc[k]) taken.push_back(1'b0);
        exp_n = 0;
        for (int r = 0; r < int'(TOP_N); r++) begin
            exp_uid[r] = 16'd0;
            exp_sc[r]  = 16'd0;
        end
        for (int r = 0; r < int'(TOP_N); r++) begin
            best = -1;
            foreach (q_sc[k]) begin
                if (!taken[k] && q_sc[k] != 16'd0 && (best < 0 || q_sc[k] > q_sc[best])) best = k;
            end
            if (best >= 0) begin
                taken[best] = 1'b1;
                exp_uid[r]  = q_uid[best];
                exp_sc[r]   = q_sc[best];
                exp_n++;
            end
        end
    endtask

    task automatic start_dump();
        q_uid = {};
        q_sc  = {};
    endtask

    task automatic send(input logic [15:0] uid, input logic [15:0] sc);
        sb_parity = ~sb_parity;
        sb_entry  = {uid, sc};
        q_uid.push_back(uid);
        q_sc.push_back(sc);
        tick();
        check("busy_in_dump", 32'(busy), 32'd1);
        check("done_in_dump", 32'(done), 32'd0);
    endtask

    task automatic finish_dump();
        bit seen;
        int r, u;
        build_model();
        sb_entry = 32'hFFFF_FFFF;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_rise", 32'(done), 32'd1);
        if (seen) begin
            for (int t = 0; t < int'(2 * DWELL * TOP_N); t++) begin
                if (t > 0) @(negedge clk);
                check("show_done", 32'(done), 32'd1);
                check("show_busy", 32'(busy), 32'd0);
                if (exp_n == 0) begin
                    check("empty_rank", 32'(disp_rank), 32'd0);
                    check("empty_valid", 32'(disp_valid), 32'd0);
                end else begin
                    r = (t / int'(DWELL)) % exp_n;
                    u = (t == 0) ? 0 : ((t - 1) / int'(DWELL)) % exp_n;
                    check("rank", 32'(disp_rank), 32'(r));
                    check("userid", 32'(disp_userid), 32'(exp_uid[u]));
                    check("score", 32'(disp_score), 32'(exp_sc[u]));
`ifndef SCORE_RANK_DISPLAY_BCD_EN
                    check("valid", 32'(disp_valid), 32'd1);
`endif
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rank"}, 32'(disp_rank), 32'd0);
        check({tag, "_userid"}, 32'(disp_userid), 32'd0);
        check({tag, "_score"}, 32'(disp_score), 32'd0);
        check({tag, "_valid"}, 32'(disp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ent;
        bit prev_b2b;

        // Reset with parity static high, then release: no event, stays idle.
        repeat (3) tick();
        check_all_zero("in_reset");
        rst = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check_all_zero("idle");

        // Mixed scores with a tie.
        start_dump();
        send(16'd1, 16'd50); repeat (3) tick();
        send(16'd2, 16'd90); repeat (3) tick();
        send(16'd3, 16'd10); repeat (3) tick();
        send(16'd4, 16'd70); repeat (3) tick();
        send(16'd5, 16'd90); repeat (3) tick();
        finish_dump();

        // Only zero scores: empty table.
        start_dump();
        send(16'd7, 16'd0); repeat (3) tick();
        send(16'd8, 16'd0); repeat (3) tick();
        finish_dump();

        // Back-to-back parity toggles.
        start_dump();
        send(16'd9, 16'd30);
        send(16'd10, 16'd40);
        repeat (3) tick();
        finish_dump();

        // Reset mid-dump drops everything and returns to idle.
        start_dump();
        send(16'd11, 16'd5); repeat (2) tick();
        send(16'd12, 16'd6);
        rst = 1'b0;
        tick();
        check_all_zero("mid_reset");
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("after_reset");

        // Random dumps: small score range for ties, occasional zeros and back-to-back toggles.
        for (int d = 0; d < 25; d++) begin
            start_dump();
            n_ent = $urandom_range(1, 8);
            prev_b2b = 1'b0;
            for (int e = 0; e < n_ent; e++) begin
                send(16'($urandom_range(1, 500)),
                     ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 20)));
                if (prev_b2b) begin
                    repeat (3) tick();
                    prev_b2b = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    prev_b2b = 1'b1;
                end else begin
                    repeat ($urandom_range(2, 3)) tick();
                end
            end
            if (prev_b2b) repeat (3) tick();
            finish_dump();
        end

`ifdef SCORE_RANK_DISPLAY_BCD_EN
        // BCD result lands 17 cycles after the rank is loaded; valid low until then.
        begin
            bit seen_b;
            start_dump();
            send(16'd1, 16'd12345);
            repeat (3) tick();
            sb_entry = 32'hFFFF_FFFF;
            seen_b = 1'b0;
            for (int k = 0; k < 40 && !seen_b; k++) begin
                @(negedge clk);
                seen_b = done;
            end
            check("bcd_done", 32'(done), 32'd1);
            for (int t = 1; t <= 17; t++) begin
                @(negedge clk);
                if (t < 17) check("bcd_valid_low", 32'(disp_valid), 32'd0);
            end
            check("bcd_value", 32'(disp_score_bcd), 32'h12345);
            check("bcd_valid_high", 32'(disp_valid), 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
